assoc_cache_ctrl: RTL and testbench
===================================

# assoc_cache_ctrl

Parametrised set-associative, write-back, write-allocate cache controller sitting between the pipelined datapath and the line-wide instruction/data memory. It generalises the existing fixed direct-mapped cache in four ways: configurable set count and way count (1 or 2), configurable line width, true LRU replacement, and dirty-line write-back. It also adds a valid/ready request handshake and saturating hit/miss counters. One instance serves one port (I or D); the top level instantiates two.

## Interface
Parameters:
- WORD_SIZE, 16, CPU word and address width
- FETCH_SIZE, 64, line width in bits; FETCH_SIZE/WORD_SIZE must be a power of two ≥ 2
- NUM_SETS, 4, power of two ≥ 2
- NUM_WAYS, 2, legal values 1 or 2

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  CPU request present
- req_write  in  1  1 = store, 0 = load
- req_addr  in  WORD_SIZE  word address
- req_wdata  in  WORD_SIZE  store data
- req_ready  out  1  high only in IDLE; a request is accepted on a clk edge where req_valid & req_ready
- resp_valid  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata  out  WORD_SIZE  load data, valid while resp_valid; 0 otherwise
- mem_read  out  1  line refill request, held until mem_ready
- mem_write  out  1  line write-back request, held until mem_ready
- mem_addr  out  WORD_SIZE  line-aligned address (offset bits 0)
- mem_wdata  out  FETCH_SIZE  victim line during write-back
- mem_rdata  in  FETCH_SIZE  refill line, sampled on the mem_ready edge
- mem_ready  in  1  one-cycle completion pulse from memory
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

## Operation
- Address split: offset = low log2(FETCH_SIZE/WORD_SIZE) bits; index = next log2(NUM_SETS) bits; tag = remaining bits. Word k of a line occupies bits [k*WORD_SIZE +: WORD_SIZE].
- Per way per set: valid, dirty, tag, line. Per set: one LRU bit (unused when NUM_WAYS = 1).
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: req_ready = 1. On acceptance, latch addr, write, and wdata; go to LOOKUP.
- LOOKUP, hit:
  - resp_valid = 1 this cycle; load returns the word.
  - Store merges the word and sets dirty.
  - LRU points to the other way; hit_count++; go to IDLE.
- LOOKUP, miss:
  - Victim = lowest-numbered invalid way, else the LRU way; latch victim; miss_count++.
  - Victim valid & dirty → WRITEBACK, else → REFILL.
- WRITEBACK: mem_write = 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line. On mem_ready → REFILL.
- REFILL: mem_read = 1, mem_addr = request line address. On mem_ready:
  - Install mem_rdata with the store word merged; valid = 1, dirty = req_write.
  - Write tag; LRU points away from the victim; go to RESPOND.
- RESPOND: resp_valid = 1; resp_rdata = requested word of the installed line; go to IDLE.
- mem_read and mem_write are never high together.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, counters = 0. All valid, dirty, and LRU bits = 0. State = IDLE.
- Hit latency: resp_valid one cycle after the acceptance edge. Peak throughput: one request per 2 cycles.
- Clean miss latency: 2 + memory latency cycles. Dirty miss adds one memory latency.
- req_valid outside IDLE is ignored; no queuing.
- mem_ready outside WRITEBACK or REFILL is ignored.
- Reset mid-operation drops mem_read and mem_write asynchronously. An in-flight request is discarded with no resp_valid, and all lines become invalid without write-back.
- A store to a line whose write-back is in progress cannot occur (single outstanding request).

## Structure
- Shared package cache_pkg holds the state enum, the offset/index/tag width functions (clog2-based), and the saturating-increment function.
- One natural sub-module: cache_way_array (per-way valid/dirty/tag/line storage, read by index, write by index+way). Controller FSM and LRU live in the top.

## Test plan
Defaults apply unless stated; memory model answers with mem_ready 4 cycles after a request.
- Cold load 0x0012 → mem_read with mem_addr 0x0010; mem_rdata 0x4444_3333_2222_1111 → resp_rdata 0x3333; miss_count = 1.
- Load 0x0013 next → resp_valid one cycle after acceptance, data 0x4444, no mem activity; hit_count = 1.
- Store 0xBEEF to 0x0011 (hit), load 0x0050 (fills way 1), load 0x0090 → write-back with mem_addr 0x0010, mem_wdata 0x4444_3333_BEEF_1111, then refill 0x0090.
- Reset asserted 2 cycles into REFILL → mem_read low the same cycle, no resp_valid. After release, req_ready = 1 and load 0x0012 misses again.
- NUM_WAYS = 1: alternate loads 0x0000 and 0x0040 four times → 4 misses, 0 hits. req_valid held during the misses is never double-accepted.
- Force miss_count to 16'hFFFE, issue 3 misses → miss_count = 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller.
// Holds the controller state enum, the address-field width helpers and the
// saturating increment used by the hit/miss counters.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        RESPOND
    } cacheState_t;

    // Number of address bits that select a word inside one line.
    function automatic int offsetBits(input int wordSize, input int fetchSize);
        return $clog2(fetchSize / wordSize);
    endfunction

    // Number of address bits that select a set.
    function automatic int indexBits(input int numSets);
        return $clog2(numSets);
    endfunction

    // Whatever is left of the word address above offset and index.
    function automatic int tagBits(input int wordSize, input int fetchSize, input int numSets);
        return wordSize - offsetBits(wordSize, fetchSize) - indexBits(numSets);
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// Per-way storage of valid, dirty, tag and line for every set.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   rdIndex           set to read; all ways of that set appear on the rd* outputs
//   rdValid, rdDirty  one bit per way
//   rdTags, rdLines   ways concatenated, way w at [w*width +: width]
//   wrEn              install/update one entry (always marks it valid)
//   wrWay, wrIndex    entry to write
//   wrDirty, wrTag, wrLine  new contents
module cache_way_array #(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    parameter int TAG_W    = 12,
    parameter int LINE_W   = 64,
    localparam int IDX_W   = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IDX_W-1:0]           rdIndex,
    output logic [NUM_WAYS-1:0]        rdValid,
    output logic [NUM_WAYS-1:0]        rdDirty,
    output logic [NUM_WAYS*TAG_W-1:0]  rdTags,
    output logic [NUM_WAYS*LINE_W-1:0] rdLines,
    input  logic                       wrEn,
    input  logic                       wrWay,
    input  logic [IDX_W-1:0]           wrIndex,
    input  logic                       wrDirty,
    input  logic [TAG_W-1:0]           wrTag,
    input  logic [LINE_W-1:0]          wrLine
);

    logic [NUM_SETS-1:0] validQ [NUM_WAYS];
    logic [NUM_SETS-1:0] dirtyQ [NUM_WAYS];
    logic [TAG_W-1:0]    tagQ   [NUM_WAYS][NUM_SETS];
    logic [LINE_W-1:0]   lineQ  [NUM_WAYS][NUM_SETS];

    // Only the status bits need a reset: an invalid entry's tag and data are
    // never looked at, so reset simply drops every line without write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                validQ[w] <= '0;
                dirtyQ[w] <= '0;
            end
        end else if (wrEn) begin
            validQ[wrWay][wrIndex] <= 1'b1;
            dirtyQ[wrWay][wrIndex] <= wrDirty;
        end
    end

    // Tag and line storage, written together with the status bits.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagQ[wrWay][wrIndex]  <= wrTag;
            lineQ[wrWay][wrIndex] <= wrLine;
        end
    end

    // Asynchronous read of every way of the addressed set, so the controller
    // can compare tags in the same cycle the set is presented.
    always_comb begin
        rdValid = '0;
        rdDirty = '0;
        rdTags  = '0;
        rdLines = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rdValid[w]                   = validQ[w][rdIndex];
            rdDirty[w]                   = dirtyQ[w][rdIndex];
            rdTags[w*TAG_W +: TAG_W]     = tagQ[w][rdIndex];
            rdLines[w*LINE_W +: LINE_W]  = lineQ[w][rdIndex];
        end
    end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Set-associative, write-back, write-allocate cache controller for one port.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   req_valid/req_write/req_addr/req_wdata, req_ready   CPU request handshake
//   resp_valid, resp_rdata           one-cycle completion pulse and load data
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata, mem_ready
//                                    line-wide memory refill/write-back port
//   hit_count, miss_count            saturating statistics counters
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int WORD_SIZE  = 16,
    parameter int FETCH_SIZE = 64,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [WORD_SIZE-1:0]  req_addr,
    input  logic [WORD_SIZE-1:0]  req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [WORD_SIZE-1:0]  resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [FETCH_SIZE-1:0] mem_wdata,
    input  logic [FETCH_SIZE-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    localparam int OFF_W = offsetBits(WORD_SIZE, FETCH_SIZE);
    localparam int IDX_W = indexBits(NUM_SETS);
    localparam int TAG_W = tagBits(WORD_SIZE, FETCH_SIZE, NUM_SETS);

    cacheState_t state, nextState;

    logic [WORD_SIZE-1:0] reqAddrQ, reqWdataQ;
    logic                 reqWriteQ;
    logic                 victimQ;
    logic [NUM_SETS-1:0]  lruQ;
    logic [15:0]          hitCountQ, missCountQ;

    logic [OFF_W-1:0] reqOffset;
    logic [IDX_W-1:0] reqIndex;
    logic [TAG_W-1:0] reqTag;

    logic [NUM_WAYS-1:0]        rdValid, rdDirty, wayHit;
    logic [NUM_WAYS*TAG_W-1:0]  rdTags;
    logic [NUM_WAYS*FETCH_SIZE-1:0] rdLines;

    logic                  hit, hitWay, victimSel;
    logic [FETCH_SIZE-1:0] hitLine, victimLine, storeLine, refillLine;
    logic [TAG_W-1:0]      victimTag;

    logic                  arrWrEn, arrWrWay, arrWrDirty;
    logic [FETCH_SIZE-1:0] arrWrLine;

    assign reqOffset = reqAddrQ[OFF_W-1:0];
    assign reqIndex  = reqAddrQ[OFF_W +: IDX_W];
    assign reqTag    = reqAddrQ[WORD_SIZE-1 -: TAG_W];

    cache_way_array #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .TAG_W    (TAG_W),
        .LINE_W   (FETCH_SIZE)
    ) wayArray (
        .clk     (clk),
        .reset   (reset),
        .rdIndex (reqIndex),
        .rdValid (rdValid),
        .rdDirty (rdDirty),
        .rdTags  (rdTags),
        .rdLines (rdLines),
        .wrEn    (arrWrEn),
        .wrWay   (arrWrWay),
        .wrIndex (reqIndex),
        .wrDirty (arrWrDirty),
        .wrTag   (reqTag),
        .wrLine  (arrWrLine)
    );

    // Tag compare and victim choice for the latched request. The victim is the
    // lowest-numbered invalid way, falling back to the set's LRU way once full.
    always_comb begin
        wayHit    = '0;
        hitWay    = 1'b0;
        victimSel = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            wayHit[w] = rdValid[w] && (rdTags[w*TAG_W +: TAG_W] == reqTag);
        end
        if (NUM_WAYS > 1) begin
            hitWay = wayHit[NUM_WAYS-1];
            if (!rdValid[0]) begin
                victimSel = 1'b0;
            end else if (!rdValid[NUM_WAYS-1]) begin
                victimSel = 1'b1;
            end else begin
                victimSel = lruQ[reqIndex];
            end
        end
    end

    assign hit        = |wayHit;
    assign hitLine    = rdLines[int'(hitWay) * FETCH_SIZE +: FETCH_SIZE];
    assign victimLine = rdLines[int'(victimQ) * FETCH_SIZE +: FETCH_SIZE];
    assign victimTag  = rdTags[int'(victimQ) * TAG_W +: TAG_W];

    // Store data merged into either the resident line (hit) or the incoming
    // refill line (write-allocate miss).
    always_comb begin
        storeLine  = hitLine;
        refillLine = mem_rdata;
        storeLine[int'(reqOffset) * WORD_SIZE +: WORD_SIZE] = reqWdataQ;
        if (reqWriteQ) begin
            refillLine[int'(reqOffset) * WORD_SIZE +: WORD_SIZE] = reqWdataQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode. Memory strobes come straight from the
    // state so that reset drops them without waiting for a clock edge.
    always_comb begin
        nextState  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        arrWrEn    = 1'b0;
        arrWrWay   = 1'b0;
        arrWrDirty = 1'b0;
        arrWrLine  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    resp_rdata = hitLine[int'(reqOffset) * WORD_SIZE +: WORD_SIZE];
                    if (reqWriteQ) begin
                        arrWrEn    = 1'b1;
                        arrWrWay   = hitWay;
                        arrWrDirty = 1'b1;
                        arrWrLine  = storeLine;
                    end
                    nextState = IDLE;
                end else if (rdValid[victimSel] && rdDirty[victimSel]) begin
                    nextState = WRITEBACK;
                end else begin
                    nextState = REFILL;
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                mem_addr  = {victimTag, reqIndex, {OFF_W{1'b0}}};
                mem_wdata = victimLine;
                if (mem_ready) begin
                    nextState = REFILL;
                end
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = {reqTag, reqIndex, {OFF_W{1'b0}}};
                if (mem_ready) begin
                    arrWrEn    = 1'b1;
                    arrWrWay   = victimQ;
                    arrWrDirty = reqWriteQ;
                    arrWrLine  = refillLine;
                    nextState  = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid = 1'b1;
                resp_rdata = victimLine[int'(reqOffset) * WORD_SIZE +: WORD_SIZE];
                nextState  = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Request latch, victim latch, LRU and statistics. An LRU bit names the
    // way to evict next, so every touch points it at the other way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reqAddrQ   <= '0;
            reqWdataQ  <= '0;
            reqWriteQ  <= 1'b0;
            victimQ    <= 1'b0;
            lruQ       <= '0;
            hitCountQ  <= '0;
            missCountQ <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                reqAddrQ  <= req_addr;
                reqWdataQ <= req_wdata;
                reqWriteQ <= req_write;
            end
            if (state == LOOKUP) begin
                if (hit) begin
                    hitCountQ      <= satInc(hitCountQ);
                    lruQ[reqIndex] <= ~hitWay;
                end else begin
                    missCountQ <= satInc(missCountQ);
                    victimQ    <= victimSel;
                end
            end
            if (state == REFILL && mem_ready) begin
                lruQ[reqIndex] <= ~victimQ;
            end
        end
    end

    assign hit_count  = hitCountQ;
    assign miss_count = missCountQ;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench for assoc_cache_ctrl: a two-way default instance and a
// one-way instance share the stimulus, selected by 'sel'. A line-level model
// (age stamps per way, backing store keyed by line address) predicts hits,
// victims, write-backs, read data, latency and counters.
module tb_assoc_cache_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel;
    logic        reqValid, reqWrite, memReady;
    logic [15:0] reqAddr, reqWdata;
    logic [63:0] memRdata;

    logic        d0Ready, d0Resp, d0MemRead, d0MemWrite;
    logic [15:0] d0Rdata, d0MemAddr, d0Hits, d0Misses;
    logic [63:0] d0MemWdata;
    logic        d1Ready, d1Resp, d1MemRead, d1MemWrite;
    logic [15:0] d1Rdata, d1MemAddr, d1Hits, d1Misses;
    logic [63:0] d1MemWdata;

    assoc_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(reqValid & ~sel), .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
        .req_ready(d0Ready), .resp_valid(d0Resp), .resp_rdata(d0Rdata),
        .mem_read(d0MemRead), .mem_write(d0MemWrite), .mem_addr(d0MemAddr), .mem_wdata(d0MemWdata),
        .mem_rdata(memRdata), .mem_ready(memReady & ~sel),
        .hit_count(d0Hits), .miss_count(d0Misses)
    );

    assoc_cache_ctrl #(.NUM_WAYS(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid & sel), .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
        .req_ready(d1Ready), .resp_valid(d1Resp), .resp_rdata(d1Rdata),
        .mem_read(d1MemRead), .mem_write(d1MemWrite), .mem_addr(d1MemAddr), .mem_wdata(d1MemWdata),
        .mem_rdata(memRdata), .mem_ready(memReady & sel),
        .hit_count(d1Hits), .miss_count(d1Misses)
    );

    logic        oReady, oResp, oMemRead, oMemWrite;
    logic [15:0] oRdata, oMemAddr, oHits, oMisses;
    logic [63:0] oMemWdata;
    assign oReady    = sel ? d1Ready    : d0Ready;
    assign oResp     = sel ? d1Resp     : d0Resp;
    assign oMemRead  = sel ? d1MemRead  : d0MemRead;
    assign oMemWrite = sel ? d1MemWrite : d0MemWrite;
    assign oRdata    = sel ? d1Rdata    : d0Rdata;
    assign oMemAddr  = sel ? d1MemAddr  : d0MemAddr;
    assign oHits     = sel ? d1Hits     : d0Hits;
    assign oMisses   = sel ? d1Misses   : d0Misses;
    assign oMemWdata = sel ? d1MemWdata : d0MemWdata;

    int checks = 0;
    int errors = 0;

    // Reference model: 4 sets x up to 2 ways, 4 words per line.
    int          nWays;
    logic        mValid [4][2];
    logic        mDirty [4][2];
    logic [11:0] mTag   [4][2];
    logic [63:0] mLine  [4][2];
    int          mStamp [4][2];
    int          stampNow;
    logic [15:0] mHits, mMisses;
    logic [63:0] backing [logic [15:0]];

    logic [15:0] lastRdata, lastWbAddr, lastRefillAddr;
    logic [63:0] lastWbData;
    int          lastLat, lastMemOps;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] memLine(input logic [15:0] lineAddr);
        if (backing.exists(lineAddr)) return backing[lineAddr];
        return {lineAddr ^ 16'h3C3C, lineAddr + 16'h0101, ~lineAddr, lineAddr ^ 16'h5A5A};
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic modelReset(input int ways);
        nWays = ways;
        stampNow = 0;
        mHits = 0;
        mMisses = 0;
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 2; w++) begin
                mValid[s][w] = 1'b0;
                mDirty[s][w] = 1'b0;
                mTag[s][w]   = '0;
                mLine[s][w]  = '0;
                mStamp[s][w] = 0;
            end
        end
    endtask

    // One complete request: entered and left at a falling edge with the DUT idle.
    // The bench also plays memory, answering 4 cycles after each request.
    task automatic applyStimulus(input logic write, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic hold);
        int          set, off, way, lat, wbSeen, rfSeen, expLat;
        logic [11:0] tag;
        logic        expHit, expWb, gotResp;
        logic [15:0] expWbAddr, expRefill, expRdata;
        logic [63:0] expWbData, line;

        set = int'(addr[3:2]);
        off = int'(addr[1:0]);
        tag = addr[15:4];
        expRefill = {addr[15:2], 2'b00};
        expHit = 1'b0;
        expWb = 1'b0;
        expWbAddr = '0;
        expWbData = '0;
        way = -1;
        for (int w = 0; w < nWays; w++) begin
            if (mValid[set][w] && mTag[set][w] == tag) begin
                expHit = 1'b1;
                way = w;
            end
        end
        if (!expHit) begin
            for (int w = 0; w < nWays; w++) begin
                if (!mValid[set][w] && way < 0) way = w;
            end
            if (way < 0) way = (nWays == 1 || mStamp[set][0] < mStamp[set][1]) ? 0 : 1;
            expWb = mValid[set][way] && mDirty[set][way];
            expWbAddr = {mTag[set][way], addr[3:2], 2'b00};
            expWbData = mLine[set][way];
        end
        line = expHit ? mLine[set][way] : memLine(expRefill);
        expRdata = line[off*16 +: 16];
        expLat = expHit ? 1 : (expWb ? 10 : 6);

        checkOutput("req_ready_idle", 64'(oReady), 64'd1);
        reqValid = 1'b1;
        reqWrite = write;
        reqAddr  = addr;
        reqWdata = wdata;
        @(negedge clk);
        if (!hold) reqValid = 1'b0;

        lat = 1;
        wbSeen = 0;
        rfSeen = 0;
        gotResp = 1'b0;
        lastWbAddr = '0;
        lastWbData = '0;
        lastRefillAddr = '0;
        while (!gotResp && lat < 60) begin
            if (oResp) begin
                gotResp = 1'b1;
                reqValid = 1'b0;
                lastRdata = oRdata;
                if (!write) checkOutput("resp_rdata", 64'(oRdata), 64'(expRdata));
            end else if (oMemWrite || oMemRead) begin
                checkOutput("mem_rw_exclusive", 64'(oMemRead & oMemWrite), 64'd0);
                if (oMemWrite) begin
                    wbSeen++;
                    lastWbAddr = oMemAddr;
                    lastWbData = oMemWdata;
                    checkOutput("wb_addr", 64'(oMemAddr), 64'(expWbAddr));
                    checkOutput("wb_data", oMemWdata, expWbData);
                end else begin
                    rfSeen++;
                    lastRefillAddr = oMemAddr;
                    checkOutput("refill_addr", 64'(oMemAddr), 64'(expRefill));
                end
                repeat (3) @(negedge clk);
                memRdata = memLine(oMemAddr);
                memReady = 1'b1;
                @(negedge clk);
                memReady = 1'b0;
                lat += 4;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        reqValid = 1'b0;
        lastLat = lat;
        lastMemOps = wbSeen + rfSeen;
        checkOutput("resp_seen", 64'(gotResp), 64'd1);
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("writebacks", 64'(wbSeen), 64'(expWb));
        checkOutput("refills", 64'(rfSeen), 64'(!expHit));

        if (expHit) begin
            mHits = sat16(mHits);
        end else begin
            mMisses = sat16(mMisses);
            if (expWb) backing[expWbAddr] = expWbData;
            mValid[set][way] = 1'b1;
            mDirty[set][way] = 1'b0;
            mTag[set][way]   = tag;
            mLine[set][way]  = memLine(expRefill);
        end
        if (write) begin
            mLine[set][way][off*16 +: 16] = wdata;
            mDirty[set][way] = 1'b1;
        end
        stampNow++;
        mStamp[set][way] = stampNow;

        @(negedge clk);
        checkOutput("hit_count", 64'(oHits), 64'(mHits));
        checkOutput("miss_count", 64'(oMisses), 64'(mMisses));
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr = '0;
        reqWdata = '0;
        memReady = 1'b0;
        memRdata = '0;
        modelReset(2);
        backing[16'h0010] = 64'h4444_3333_2222_1111;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 64'(oReady), 64'd1);
        checkOutput("rst_resp_valid", 64'(oResp), 64'd0);
        checkOutput("rst_resp_rdata", 64'(oRdata), 64'd0);
        checkOutput("rst_mem_read", 64'(oMemRead), 64'd0);
        checkOutput("rst_mem_write", 64'(oMemWrite), 64'd0);
        checkOutput("rst_mem_addr", 64'(oMemAddr), 64'd0);
        checkOutput("rst_mem_wdata", oMemWdata, 64'd0);
        checkOutput("rst_hits", 64'(oHits), 64'd0);
        checkOutput("rst_misses", 64'(oMisses), 64'd0);
        reset = 1'b0;

        // Cold load, hit, store hit, second-way fill, dirty eviction.
        applyStimulus(1'b0, 16'h0012, 16'h0000, 1'b0);
        checkOutput("cold_refill_addr", 64'(lastRefillAddr), 64'h0010);
        checkOutput("cold_rdata", 64'(lastRdata), 64'h3333);
        checkOutput("cold_misses", 64'(oMisses), 64'd1);
        applyStimulus(1'b0, 16'h0013, 16'h0000, 1'b0);
        checkOutput("hit_latency", 64'(lastLat), 64'd1);
        checkOutput("hit_rdata", 64'(lastRdata), 64'h4444);
        checkOutput("hit_no_mem", 64'(lastMemOps), 64'd0);
        checkOutput("hit_hits", 64'(oHits), 64'd1);
        applyStimulus(1'b1, 16'h0011, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 16'h0050, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0090, 16'h0000, 1'b0);
        checkOutput("evict_wb_addr", 64'(lastWbAddr), 64'h0010);
        checkOutput("evict_wb_data", lastWbData, 64'h4444_3333_BEEF_1111);
        checkOutput("evict_refill_addr", 64'(lastRefillAddr), 64'h0090);

        // Reset two cycles into a refill.
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr = 16'h00A2;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_mem_read", 64'(oMemRead), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_mem_read", 64'(oMemRead), 64'd0);
        checkOutput("midrst_resp", 64'(oResp), 64'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("midrst_no_resp", 64'(oResp), 64'd0);
        end
        reset = 1'b0;
        modelReset(2);
        checkOutput("postrst_req_ready", 64'(oReady), 64'd1);
        checkOutput("postrst_misses", 64'(oMisses), 64'd0);
        applyStimulus(1'b0, 16'h0012, 16'h0000, 1'b0);
        checkOutput("postrst_miss_latency", 64'(lastLat), 64'd6);

        // Randomized mix over 8 tags x 4 sets to provoke conflicts and evictions.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'h007F)),
                          16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Miss counter saturation.
        force dut.missCountQ = 16'hFFFE;
        #1;
        release dut.missCountQ;
        mMisses = 16'hFFFE;
        applyStimulus(1'b0, 16'h8000, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h8100, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h8200, 16'h0000, 1'b0);
        checkOutput("sat_misses", 64'(oMisses), 64'hFFFF);

        // Direct-mapped instance, request held high through every miss.
        sel = 1'b1;
        modelReset(1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, (i % 2 == 0) ? 16'h0000 : 16'h0040, 16'h0000, 1'b1);
        end
        checkOutput("dm_misses", 64'(oMisses), 64'd4);
        checkOutput("dm_hits", 64'(oHits), 64'd0);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
